// File: rtl/regadd_checker_if.sv
// regadd_checker_if: stimulus, DUT/reference results and mismatch-log read port of the adder checker
interface regadd_checker_if #(parameter int n = 8);
    logic           enable;
    logic [n-1:0]   a, b;
    logic           c_in, select;
    logic [n-1:0]   dut_sum, ref_sum;
    logic           dut_c_out, ref_c_out;
    logic           rd_valid, rd_ready;
    logic [3*n+2:0] rd_data;
    modport master(output enable, a, b, c_in, select, dut_sum, dut_c_out, ref_sum, ref_c_out, rd_ready,
                   input rd_valid, rd_data);
    modport slave(input enable, a, b, c_in, select, dut_sum, dut_c_out, ref_sum, ref_c_out, rd_ready,
                  output rd_valid, rd_data);
endinterface

// File: rtl/regadd_checker.sv
// regadd_checker: aligns adder stimulus to its registered outputs, compares against the reference,
// counts vectors/mismatches and logs mismatch records; the log FIFO exists only with REGADD_CHK_LOG_EN
module regadd_checker #(
    parameter int n     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic              clk,
    input  logic              rst,
    regadd_checker_if.slave   bus,
    output logic [CW-1:0]     err_count,
    output logic [2*n+2:0]    vec_count,
    output logic              error,
    output logic              overflow,
    output logic              done
);
    localparam int SW = 2*n+2;
    localparam int RW = 3*n+3;

    logic          valid_q;
    logic [SW-1:0] stim_q;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [2*n+2:0] vec_count_q, vec_count_d;
    logic          error_q, overflow_q, overflow_d;
    logic          mismatch, drop;
    logic [RW-1:0] rec;

    assign mismatch = valid_q && ((bus.dut_c_out != bus.ref_c_out) || (bus.dut_sum != bus.ref_sum));
    assign rec      = {stim_q, bus.dut_c_out, bus.dut_sum};

    // Stage 0: register the stimulus so it lines up with the adder's registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            stim_q  <= '0;
        end else begin
            valid_q <= bus.enable;
            stim_q  <= {bus.c_in, bus.a, bus.b, bus.select};
        end
    end

    // The count saturates at 2^(2n+2), which is exactly its MSB, so done is that bit
    always_comb begin
        vec_count_d = (valid_q && !vec_count_q[2*n+2]) ? vec_count_q + (2*n+3)'(1) : vec_count_q;
        err_count_d = (mismatch && !(&err_count_q)) ? err_count_q + CW'(1) : err_count_q;
        overflow_d  = overflow_q | drop;
    end

    // Stage 1: count checks and mismatches, latch the sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count_q <= '0;
            err_count_q <= '0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            error_q     <= error_q | mismatch;
            overflow_q  <= overflow_d;
        end
    end

    assign err_count = err_count_q;
    assign vec_count = vec_count_q;
    assign error     = error_q;
    assign overflow  = overflow_q;
    assign done      = vec_count_q[2*n+2];

`ifdef REGADD_CHK_LOG_EN
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [RW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   occ_q;
    logic          full, push, pop;

    assign full = occ_q == FULL;
    assign pop  = bus.rd_valid && bus.rd_ready;
    assign push = mismatch && (!full || pop);
    assign drop = mismatch && full && !pop;

    // Log pointers and occupancy; a push and pop together leave occupancy unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            occ_q    <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Log storage needs no reset: stale entries are hidden behind the occupancy count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rec;
    end

    assign bus.rd_valid = occ_q != '0;
    assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr_q] : '0;
`else
    logic unused_ok;

    assign drop         = mismatch;
    assign bus.rd_valid = 1'b0;
    assign bus.rd_data  = '0;
    assign unused_ok    = (^{bus.rd_ready, rec}) ^ DEPTH[0];
`endif
endmodule

// File: tb/tb_regadd_checker.sv
// tb_regadd_checker: directed checks of regadd_checker (log checks adapt to REGADD_CHK_LOG_EN)
module tb_regadd_checker;
`ifdef REGADD_CHK_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    regadd_checker_if #(.n(8)) m ();
    regadd_checker_if #(.n(3)) s ();

    logic [15:0] m_err;
    logic [18:0] m_vec;
    logic        m_error, m_ovf, m_done;
    logic [1:0]  s_err;
    logic [8:0]  s_vec;
    logic        s_error, s_ovf, s_done;

    regadd_checker #(.n(8), .DEPTH(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .bus(m), .err_count(m_err), .vec_count(m_vec),
        .error(m_error), .overflow(m_ovf), .done(m_done));

    regadd_checker #(.n(3), .DEPTH(2), .CW(2)) dut_s (
        .clk(clk), .rst(rst), .bus(s), .err_count(s_err), .vec_count(s_vec),
        .error(s_error), .overflow(s_ovf), .done(s_done));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [7:0] a, input logic [7:0] ds, input logic [7:0] rs);
        m.enable = en;
        m.a = a;
        m.b = 8'h00;
        m.c_in = 1'b0;
        m.select = 1'b0;
        m.dut_sum = ds;
        m.ref_sum = rs;
        m.dut_c_out = 1'b0;
        m.ref_c_out = 1'b0;
    endtask

    function automatic logic [26:0] rec(input int k);
        logic [7:0] a;
        a = 8'(k);
        return {1'b0, a, 8'h00, 1'b0, 1'b0, a ^ 8'h80};
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, " err_count"}, 64'(m_err), 0);
        chk({tag, " vec_count"}, 64'(m_vec), 0);
        chk({tag, " error"}, 64'(m_error), 0);
        chk({tag, " overflow"}, 64'(m_ovf), 0);
        chk({tag, " done"}, 64'(m_done), 0);
        chk({tag, " rd_valid"}, 64'(m.rd_valid), 0);
        chk({tag, " rd_data"}, 64'(m.rd_data), 0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        m.rd_ready = 1'b0;
        s.enable = 1'b0;
        {s.c_in, s.a, s.b, s.select} = 8'h00;
        s.dut_sum = 3'd0;
        s.ref_sum = 3'd0;
        s.dut_c_out = 1'b0;
        s.ref_c_out = 1'b0;
        s.rd_ready = 1'b0;
        repeat (2) step();
        all_zero("reset");
        rst = 1'b0;

        // 100 matching vectors counting from 0
        for (int i = 0; i < 100; i++) begin
            m.enable = 1'b1;
            {m.c_in, m.a, m.b, m.select} = 18'(i);
            m.dut_sum = 8'(i);
            m.ref_sum = 8'(i);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        step();
        chk("clean vec_count", 64'(m_vec), 100);
        chk("clean err_count", 64'(m_err), 0);
        chk("clean error", 64'(m_error), 0);
        chk("clean rd_valid", 64'(m.rd_valid), 0);
        chk("clean done", 64'(m_done), 0);

        // single mismatch a=7, dut_sum=0x08 vs ref_sum=0x07
        drive(1'b1, 8'h07, 8'h00, 8'h00);
        step();
        drive(1'b0, 8'h00, 8'h08, 8'h07);
        step();
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("one err_count", 64'(m_err), 1);
        chk("one error", 64'(m_error), 1);
        chk("one vec_count", 64'(m_vec), 101);
        chk("one rd_valid", 64'(m.rd_valid), 64'(LOG));
        chk("one rd_data", 64'(m.rd_data), LOG ? 64'({1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'h08}) : 0);
        chk("one overflow", 64'(m_ovf), 64'(!LOG));

        // second logged mismatch, then reset mid-run for 3 cycles
        drive(1'b1, 8'h09, 8'h00, 8'h00);
        step();
        drive(1'b0, 8'h00, 8'h89, 8'h09);
        step();
        chk("two err_count", 64'(m_err), 2);
        drive(1'b1, 8'h05, 8'h00, 8'h00);
        step();
        drive(1'b1, 8'h06, 8'h85, 8'h05);
        rst = 1'b1;
        #1;
        all_zero("in_reset");
        repeat (3) step();
        all_zero("end_reset");
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;
        repeat (2) step();
        all_zero("post_reset");

        // six mismatches with reader stalled
        for (int j = 0; j <= 6; j++) begin
            drive(j < 6, 8'(j + 1), j > 0 ? 8'(j) ^ 8'h80 : 8'h00, j > 0 ? 8'(j) : 8'h00);
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("six err_count", 64'(m_err), 6);
        chk("six vec_count", 64'(m_vec), 6);
        chk("six overflow", 64'(m_ovf), 1);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain%0d rd_valid", k), 64'(m.rd_valid), 64'(LOG));
            chk($sformatf("drain%0d rd_data", k), 64'(m.rd_data), LOG ? 64'(rec(k)) : 0);
            m.rd_ready = 1'b1;
            step();
            m.rd_ready = 1'b0;
        end
        chk("drained rd_valid", 64'(m.rd_valid), 0);

        // fill to 4, then push and pop together for 3 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j <= 7; j++) begin
            if (j >= 5) chk($sformatf("through head%0d", j - 4), 64'(m.rd_data), LOG ? 64'(rec(j - 4)) : 0);
            m.rd_ready = j >= 5;
            drive(j < 7, 8'(j + 1), j > 0 ? 8'(j) ^ 8'h80 : 8'h00, j > 0 ? 8'(j) : 8'h00);
            step();
        end
        m.rd_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00);
        chk("through overflow", 64'(m_ovf), 64'(!LOG));
        chk("through err_count", 64'(m_err), 7);
        for (int k = 4; k <= 7; k++) begin
            chk($sformatf("through drain%0d rd_valid", k), 64'(m.rd_valid), 64'(LOG));
            chk($sformatf("through drain%0d rd_data", k), 64'(m.rd_data), LOG ? 64'(rec(k)) : 0);
            m.rd_ready = 1'b1;
            step();
            m.rd_ready = 1'b0;
        end
        chk("through empty rd_valid", 64'(m.rd_valid), 0);

        // full vector-space sweep on the n=3 instance: done after the 256th check
        for (int i = 0; i < 260; i++) begin
            s.enable = 1'b1;
            {s.c_in, s.a, s.b, s.select} = 8'(i);
            step();
            if (i == 255) begin
                chk("sweep vec_count 255", 64'(s_vec), 255);
                chk("sweep done early", 64'(s_done), 0);
            end
            if (i == 256) begin
                chk("sweep vec_count 256", 64'(s_vec), 256);
                chk("sweep done", 64'(s_done), 1);
            end
        end
        chk("sweep vec_count hold", 64'(s_vec), 256);
        chk("sweep done hold", 64'(s_done), 1);
        chk("sweep err_count", 64'(s_err), 0);

        // err_count saturates at all-ones (CW=2)
        s.ref_sum = 3'd1;
        repeat (2) step();
        chk("sat err_count 2", 64'(s_err), 2);
        repeat (3) step();
        chk("sat err_count 3", 64'(s_err), 3);
        chk("sat error", 64'(s_error), 1);
        chk("sat overflow", 64'(s_ovf), 1);
        chk("sat vec_count", 64'(s_vec), 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
